// File: rtl/ram_pkg.sv
// Shared definitions for the behavioural RAM family.
// Holds the write-mode names, the legal read-latency range and a helper
// that derives the number of byte-enable lanes from word and lane widths.
package ram_pkg;

    localparam string WM_WRITE_FIRST = "write_first";
    localparam string WM_READ_FIRST  = "read_first";
    localparam string WM_NO_CHANGE   = "no_change";

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 3;

    function automatic int unsigned num_lanes(input int unsigned dw, input int unsigned bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data delay line of STAGES registers carrying {valid, data}.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high clear of every valid and data register
//   in_valid  valid bit entering the first stage
//   in_data   data entering the first stage
//   out_valid valid bit leaving the last stage
//   out_data  data leaving the last stage (holds when no valid word passes)
module ram_rd_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];

    // Data registers only load alongside a valid bit so the output holds
    // the last delivered word while the pipe is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int unsigned i = 0; i < STAGES; i++) d[i] <= '0;
        end else begin
            v[0] <= in_valid;
            if (in_valid) d[0] <= in_data;
            for (int unsigned i = 1; i < STAGES; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) d[i] <= d[i-1];
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];

endmodule

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM with byte-lane write enables, selectable
// write mode and 1..3 cycle registered read latency with a valid strobe.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (clears read pipeline, not memory)
//   en     access enable
//   we     per-lane write enables, qualified by en
//   addr   word address (addresses >= DEPTH drop writes and read as 0)
//   din    write data
//   dout   read data, valid while rvalid=1, otherwise holds
//   rvalid read data valid strobe
module sp_ram_be
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned LATENCY    = 1,
    parameter string       WRITE_MODE = "write_first",
    parameter bit          INIT_ZERO  = 1'b1,
    localparam int unsigned LANES     = num_lanes(DATA_WIDTH, BYTE_WIDTH),
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [LANES-1:0]      we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rvalid
);

    localparam bit IS_READ_FIRST = (WRITE_MODE == WM_READ_FIRST);
    localparam bit IS_NO_CHANGE  = (WRITE_MODE == WM_NO_CHANGE);
    localparam logic [DATA_WIDTH-1:0] INIT_WORD = INIT_ZERO ? '0 : 'x;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("sp_ram_be: LATENCY %0d outside legal range", LATENCY);
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
        $error("sp_ram_be: DATA_WIDTH not a multiple of BYTE_WIDTH");
    end
    if (WRITE_MODE != WM_WRITE_FIRST && !IS_READ_FIRST && !IS_NO_CHANGE) begin : g_bad_mode
        $error("sp_ram_be: unknown WRITE_MODE");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_WORD};

    logic                  in_range;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] capture;
    logic                  is_read;
    logic                  s1_v;
    logic [DATA_WIDTH-1:0] s1_d;

    if (DEPTH == (2 ** AW)) begin : g_pow2
        assign in_range = 1'b1;
    end else begin : g_npow2
        assign in_range = (addr < AW'(DEPTH));
    end

    always_comb begin
        old_word = in_range ? mem[addr] : '0;
        merged   = old_word;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (we[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        // Out-of-range reads return zero even when merged carries din bytes.
        if (!in_range)          capture = '0;
        else if (IS_READ_FIRST) capture = old_word;
        else                    capture = merged;
        is_read = en && (!(|we) || !IS_NO_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (!rst && en && in_range) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (we[i]) mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_d <= '0;
        end else begin
            s1_v <= is_read;
            if (is_read) s1_d <= capture;
        end
    end

    if (LATENCY == 1) begin : g_lat1
        assign dout   = s1_d;
        assign rvalid = s1_v;
    end else begin : g_latn
        ram_rd_pipe #(
            .WIDTH  (DATA_WIDTH),
            .STAGES (LATENCY - 1)
        ) u_pipe (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (s1_v),
            .in_data   (s1_d),
            .out_valid (rvalid),
            .out_data  (dout)
        );
    end

    a_no_x_ctrl: assert property (@(posedge clk) disable iff (rst) !$isunknown({en, we}))
        else $error("sp_ram_be: X on en/we");

endmodule

// File: tb/tb_sp_ram_be.sv
module tb_sp_ram_be;

    localparam int NI = 6;
    localparam int LAT  [NI] = '{1, 1, 1, 3, 2, 1};
    localparam int MODE [NI] = '{0, 1, 2, 0, 0, 0};   // 0 wf, 1 rf, 2 nc
    localparam int DEP  [NI] = '{128, 128, 128, 128, 128, 100};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  we = '0;
    logic [6:0]  addr = '0;
    logic [31:0] din = '0;
    logic [31:0] do_a [NI];
    logic        rv_a [NI];

    always #5 clk = ~clk;

    sp_ram_be #(.LATENCY(1), .WRITE_MODE("write_first")) u_wf (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(do_a[0]), .rvalid(rv_a[0]));
    sp_ram_be #(.LATENCY(1), .WRITE_MODE("read_first")) u_rf (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(do_a[1]), .rvalid(rv_a[1]));
    sp_ram_be #(.LATENCY(1), .WRITE_MODE("no_change")) u_nc (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(do_a[2]), .rvalid(rv_a[2]));
    sp_ram_be #(.LATENCY(3), .WRITE_MODE("write_first")) u_l3 (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(do_a[3]), .rvalid(rv_a[3]));
    sp_ram_be #(.LATENCY(2), .WRITE_MODE("write_first")) u_l2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(do_a[4]), .rvalid(rv_a[4]));
    sp_ram_be #(.DEPTH(100), .LATENCY(1), .WRITE_MODE("write_first")) u_np (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(do_a[5]), .rvalid(rv_a[5]));

    // Reference model: memory image plus a queue of pending read results,
    // each tagged with the edge count at which it must appear.
    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    logic [31:0] mm [NI][128];
    pend_t       pq [NI][$];
    logic [31:0] exp_do [NI];
    logic        exp_rv [NI];
    int          ecount = 0;
    bit          known = 0;
    int          tests = 0;
    int          fails = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic model_edge();
        logic        inr;
        logic [31:0] old, nw, rd;
        pend_t       p;
        ecount++;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                pq[k].delete();
                exp_rv[k] = 1'b0;
                exp_do[k] = '0;
            end else begin
                if (en) begin
                    inr = (int'(addr) < DEP[k]);
                    old = inr ? mm[k][addr] : 32'h0;
                    nw  = old;
                    for (int b = 0; b < 4; b++) if (we[b]) nw[8*b +: 8] = din[8*b +: 8];
                    if (inr && we != 4'b0) mm[k][addr] = nw;
                    rd = !inr ? 32'h0 : ((MODE[k] == 1) ? old : nw);
                    if (we == 4'b0 || MODE[k] != 2) begin
                        p.due  = ecount + LAT[k] - 1;
                        p.data = rd;
                        pq[k].push_back(p);
                    end
                end
                if (pq[k].size() != 0 && pq[k][0].due == ecount) begin
                    p = pq[k].pop_front();
                    exp_rv[k] = 1'b1;
                    exp_do[k] = p.data;
                end else begin
                    exp_rv[k] = 1'b0;
                end
            end
        end
        if (rst) known = 1;
    endtask

    task automatic cycle(input logic r, input logic e, input logic [3:0] w,
                         input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = r; en = e; we = w; addr = a; din = d;
        @(posedge clk);
        model_edge();
        #1;
        if (known) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("model_rvalid[%0d]", k), {31'b0, rv_a[k]}, {31'b0, exp_rv[k]});
                chk($sformatf("model_dout[%0d]", k), do_a[k], exp_do[k]);
            end
        end
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [6:0]  addr;
        logic [31:0] din;
        logic        rv;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl [10];

    initial begin
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 128; i++) mm[k][i] = '0;

        // Byte merge and idle hold on the write_first LATENCY=1 instance.
        tbl[0] = '{1'b1, 4'b1111, 7'd5, 32'hAABBCCDD, 1'b1, 32'hAABBCCDD};
        tbl[1] = '{1'b1, 4'b0101, 7'd5, 32'h11223344, 1'b1, 32'hAA22CC44};
        tbl[2] = '{1'b1, 4'b0000, 7'd5, 32'h0,        1'b1, 32'hAA22CC44};
        tbl[3] = '{1'b1, 4'b1111, 7'd7, 32'h00001234, 1'b1, 32'h00001234};
        tbl[4] = '{1'b1, 4'b0000, 7'd7, 32'h0,        1'b1, 32'h00001234};
        for (int i = 5; i < 10; i++) tbl[i] = '{1'b0, 4'b0000, 7'd0, 32'h0, 1'b0, 32'h00001234};

        cycle(1'b1, 1'b0, 4'h0, 7'd0, 32'h0);
        cycle(1'b1, 1'b1, 4'hF, 7'd9, 32'hFFFFFFFF);
        for (int k = 0; k < NI; k++) begin
            chk("reset_rvalid", {31'b0, rv_a[k]}, 32'h0);
            chk("reset_dout", do_a[k], 32'h0);
        end

        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].din);
            chk($sformatf("tbl%0d_rvalid", i), {31'b0, rv_a[0]}, {31'b0, tbl[i].rv});
            chk($sformatf("tbl%0d_dout", i), do_a[0], tbl[i].dout);
        end

        // Write modes: addr 3 preloaded to zero, then a full-word write.
        cycle(1'b0, 1'b1, 4'hF, 7'd3, 32'h0);
        cycle(1'b0, 1'b1, 4'hF, 7'd3, 32'hDEADBEEF);
        chk("wf_rvalid", {31'b0, rv_a[0]}, 32'h1);
        chk("wf_dout", do_a[0], 32'hDEADBEEF);
        chk("rf_rvalid", {31'b0, rv_a[1]}, 32'h1);
        chk("rf_dout", do_a[1], 32'h0);
        chk("nc_rvalid", {31'b0, rv_a[2]}, 32'h0);
        chk("nc_dout_hold", do_a[2], 32'h00001234);
        cycle(1'b0, 1'b1, 4'h0, 7'd3, 32'h0);
        for (int k = 0; k < 3; k++) chk("mode_readback", do_a[k], 32'hDEADBEEF);

        // LATENCY=3 streaming of addrs 0..7.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 4'hF, 7'(i), 32'(i * 32'h101));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'h0);
        for (int j = 0; j < 12; j++) begin
            if (j < 8) cycle(1'b0, 1'b1, 4'h0, 7'(j), 32'h0);
            else       cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'h0);
            if (j >= 2 && j < 10) begin
                chk("l3_rvalid", {31'b0, rv_a[3]}, 32'h1);
                chk("l3_dout", do_a[3], 32'((j - 2) * 32'h101));
            end else begin
                chk("l3_idle_rvalid", {31'b0, rv_a[3]}, 32'h0);
            end
        end

        // Reset mid-flight on the LATENCY=2 instance.
        cycle(1'b0, 1'b1, 4'hF, 7'd0, 32'hCAFE0000);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'h0);
        cycle(1'b0, 1'b1, 4'h0, 7'd0, 32'h0);
        cycle(1'b1, 1'b1, 4'hF, 7'd0, 32'hFFFFFFFF);
        chk("rstmid_rvalid0", {31'b0, rv_a[4]}, 32'h0);
        chk("rstmid_dout0", do_a[4], 32'h0);
        cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'h0);
        chk("rstmid_rvalid1", {31'b0, rv_a[4]}, 32'h0);
        chk("rstmid_dout1", do_a[4], 32'h0);
        cycle(1'b0, 1'b1, 4'h0, 7'd0, 32'h0);
        cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'h0);
        chk("rstmid_mem_rvalid", {31'b0, rv_a[4]}, 32'h1);
        chk("rstmid_mem_kept", do_a[4], 32'hCAFE0000);

        // Non-power-of-two depth on the DEPTH=100 instance.
        cycle(1'b0, 1'b1, 4'hF, 7'd99, 32'h00000099);
        cycle(1'b0, 1'b1, 4'hF, 7'd100, 32'h00000055);
        chk("oor_wr_rvalid", {31'b0, rv_a[5]}, 32'h1);
        chk("oor_wr_dout", do_a[5], 32'h0);
        cycle(1'b0, 1'b1, 4'h0, 7'd100, 32'h0);
        chk("oor_rd_rvalid", {31'b0, rv_a[5]}, 32'h1);
        chk("oor_rd_dout", do_a[5], 32'h0);
        cycle(1'b0, 1'b1, 4'h0, 7'd99, 32'h0);
        chk("addr99_rvalid", {31'b0, rv_a[5]}, 32'h1);
        chk("addr99_dout", do_a[5], 32'h00000099);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            logic        r, e;
            logic [3:0]  w;
            r = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            cycle(r, e, w, 7'($urandom_range(0, 127)), $urandom);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
